// File: rtl/cpu_pkg.sv
// cpu_pkg: shared loader state type, opcode and width constants (CHK exists only with PROG_LOADER_CHECKSUM_EN)
package cpu_pkg;
    localparam int INSN_W = 8;
    localparam int ADDR_W = 5;
    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] JMP = 3'b111;
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, FILL, CHK, RUN, ERR} loader_state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, ERR} loader_state_t;
`endif
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: counts idle cycles between received bytes and flags the last allowed one
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] count;
    assign Expired = Enable && count == W'(TIMEOUT_CYC - 1);
    // idle-cycle counter, restarted by every byte and whenever no byte is awaited
    always_ff @(posedge Clk)
        count <= (Reset || Clear) ? '0 : Enable ? count + 1'b1 : count;
endmodule

// File: rtl/program_loader.sv
// program_loader: UART-to-instruction-memory download sequencer with HLT padding; PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte
module program_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int END_ON_HLT  = 1,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Rx_valid,
    input  logic [INSN_W-1:0] Rx_data,
    input  logic              Rx_fe,
    output logic              Load,
    output logic              Wr_en,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [INSN_W-1:0] Wr_data,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W:0]   Byte_count
);
    localparam int CW = ADDR_W + 1;
    loader_state_t state, state_n;
    logic [CW-1:0] fill_ptr, fill_n, count_n;
    logic [ADDR_W-1:0] addr_n;
    logic [INSN_W-1:0] data_n;
    logic we_n, err_n, waiting, busy_n, tm_exp;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INSN_W-1:0] sum, sum_n;
    assign waiting = state == LOAD || state == CHK;
    assign busy_n  = state_n == LOAD || state_n == FILL || state_n == CHK;
`else
    assign waiting = state == LOAD;
    assign busy_n  = state_n == LOAD || state_n == FILL;
`endif
    loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (Rx_valid || !waiting),
        .Enable (waiting && !Rx_valid),
        .Expired(tm_exp)
    );
    // next state, next write port values and counter updates
    always_comb begin
        state_n = state;
        count_n = Byte_count;
        fill_n  = fill_ptr;
        we_n    = 1'b0;
        addr_n  = Wr_addr;
        data_n  = Wr_data;
        err_n   = Error;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_n   = sum;
`endif
        case (state)
            IDLE, RUN, ERR: if (Start) begin
                state_n = LOAD;
                count_n = '0;
                err_n   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_n   = '0;
`endif
            end
            LOAD: if (Rx_valid && Rx_fe) state_n = ERR;
            else if (Rx_valid) begin
                we_n    = 1'b1;
                addr_n  = Byte_count[ADDR_W-1:0];
                data_n  = Rx_data;
                count_n = Byte_count + 1'b1;
                fill_n  = count_n;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_n   = sum + Rx_data;
`endif
                state_n = (count_n == CW'(DEPTH) || (END_ON_HLT != 0 && Rx_data[7:5] == HLT)) ? FILL : LOAD;
            end else if (tm_exp) state_n = ERR;
            FILL: if (fill_ptr == CW'(DEPTH)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_n = CHK;
`else
                state_n = RUN;
`endif
            end else begin
                we_n   = 1'b1;
                addr_n = fill_ptr[ADDR_W-1:0];
                data_n = '0;
                fill_n = fill_ptr + 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: if (Rx_valid) state_n = (!Rx_fe && Rx_data == sum) ? RUN : ERR;
            else if (tm_exp) state_n = ERR;
`endif
            default: state_n = IDLE;
        endcase
        if (state_n == ERR) err_n = 1'b1;
    end
    // registered state and outputs; Load drops and Done pulses only on entry to RUN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            Load       <= 1'b1;
            Wr_en      <= 1'b0;
            Wr_addr    <= '0;
            Wr_data    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
            Byte_count <= '0;
            fill_ptr   <= '0;
        end else begin
            state      <= state_n;
            Load       <= state_n != RUN;
            Wr_en      <= we_n;
            Wr_addr    <= addr_n;
            Wr_data    <= data_n;
            Busy       <= busy_n;
            Done       <= state_n == RUN && state != RUN;
            Error      <= err_n;
            Byte_count <= count_n;
            fill_ptr   <= fill_n;
        end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    // running mod-256 sum of accepted program bytes
    always_ff @(posedge Clk)
        sum <= Reset ? '0 : sum_n;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed download checks against a memory-image reference model
module tb_program_loader;
    localparam int TMO = 100;
    typedef logic [7:0] bq_t[$];
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0, rx_fe = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic load, wr_en, busy, done, error;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] byte_count;
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [4:0] wa[$];
    logic [7:0] wd[$];
    int wt[$];

    program_loader #(.DEPTH(32), .END_ON_HLT(1), .TIMEOUT_CYC(TMO)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Rx_valid(rx_valid), .Rx_data(rx_data), .Rx_fe(rx_fe),
        .Load(load), .Wr_en(wr_en), .Wr_addr(wr_addr), .Wr_data(wr_data), .Busy(busy), .Done(done),
        .Error(error), .Byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // write and Done monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (wr_en === 1'b1) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wt.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log;
        wa.delete();
        wd.delete();
        wt.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_fe    = fe;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_fe    = 1'b0;
        tick(gap);
    endtask

    task automatic run_download(input bq_t raw, input bit extra);
        bq_t acc;
        logic [7:0] s;
        acc = {};
        s = 8'h00;
        foreach (raw[i]) begin
            if (acc.size() == 32) break;
            acc.push_back(raw[i]);
            s += raw[i];
            if (raw[i][7:5] == 3'b000) break;
        end
        clear_log();
        pulse_start();
        foreach (acc[i]) send_byte(acc[i], 1'b0, (i == acc.size() - 1) ? 0 : int'($urandom_range(0, 3)));
        if (extra) send_byte(8'h5A, 1'b0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        tick(40);
        send_byte(s, 1'b0, 0);
`endif
        for (int k = 0; k < 300 && done_cnt == 0; k++) tick(1);
        tick(3);
        chk("done_pulse", done_cnt, 1);
        chk("load_released", load, 1'b0);
        chk("byte_count", byte_count, acc.size());
        chk("busy_after", busy, 1'b0);
        chk("error_after", error, 1'b0);
        chk("write_count", wa.size(), 32);
        for (int i = 0; i < 32 && i < wa.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), wa[i], i);
            chk($sformatf("wr_data[%0d]", i), wd[i], (i < acc.size()) ? acc[i] : 8'h00);
        end
`ifndef PROG_LOADER_CHECKSUM_EN
        chk("run_after_last_write", done_cyc, (wt.size() > 0) ? wt[wt.size() - 1] + 1 : -1);
`endif
    endtask

    initial begin
        bq_t q;
        tick(3);
        chk("rst_load", load, 1'b1);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 5'd0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_byte_count", byte_count, 6'd0);
        reset = 1'b0;
        tick(2);

        run_download('{8'hA1, 8'h42, 8'h00}, 1'b1);

        q = {};
        for (int i = 0; i < 32; i++) q.push_back(8'(8'h20 + i));
        run_download(q, 1'b0);

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 32);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            if (n < 32) q[n - 1][7:5] = 3'b000;
            run_download(q, r[0]);
        end

        clear_log();
        pulse_start();
        send_byte(8'hE5, 1'b0, 1);
        send_byte(8'h77, 1'b1, 1);
        chk("fe_error", error, 1'b1);
        chk("fe_load", load, 1'b1);
        chk("fe_busy", busy, 1'b0);
        chk("fe_write_count", wa.size(), 1);
        chk("fe_write_data", (wd.size() > 0) ? {24'h0, wd[0]} : 32'hDEAD, 8'hE5);
        pulse_start();
        chk("start_clears_error", error, 1'b0);
        chk("restart_busy", busy, 1'b1);

        clear_log();
        send_byte(8'h2C, 1'b0, 0);
        tick(TMO - 1);
        chk("no_timeout_yet", error, 1'b0);
        tick(1);
        chk("timeout_error", error, 1'b1);
        chk("timeout_load", load, 1'b1);
        chk("timeout_writes", wa.size(), 1);

        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h20 | $urandom_range(0, 31)), 1'b0, $urandom_range(0, 2));
        tick(1);
        chk("mid_byte_count", byte_count, 6'd5);
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_load", load, 1'b1);
        chk("mid_rst_byte_count", byte_count, 6'd0);
        chk("mid_rst_wr_en", wr_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_error", error, 1'b0);
        tick(2);

        run_download('{8'h21, 8'h22, 8'h00}, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        clear_log();
        pulse_start();
        send_byte(8'h21, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h00, 1'b0, 40);
        send_byte(8'h44, 1'b0, 2);
        chk("bad_sum_error", error, 1'b1);
        chk("bad_sum_load", load, 1'b1);
        chk("bad_sum_no_done", done_cnt, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
